if_fetch_unit: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and drives the instruction SRAM request.
- Consumes the branch redirect bus {br_e, br_addr} produced by decode.
- Produces the {ce, pc} bus and a stall-safe instruction word for decode. It buffers a redirect that arrives during a stall and holds the SRAM read data across decode stalls.

---
 rtl/if_fetch_unit_pkg.sv | 31 +++
 rtl/if_fetch_unit_inst_hold_buf.sv | 63 ++++++
 rtl/if_fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// ============================================================================
// if_fetch_unit_pkg : shared widths, encodings and reset constant for IF stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package if_fetch_unit_pkg;

    localparam int          DEF_STALL_W  = 6;
    localparam logic        STOP         = 1'b1;
    localparam logic        NO_STOP      = 1'b0;

    localparam int          IF_TO_ID_WD  = 33;
    localparam int          BR_WD        = 33;

    // First fetched word is DEF_RESET_PC + 4 = 32'hBFC0_0000.
    localparam logic [31:0] DEF_RESET_PC = 32'hBFBF_FFFC;

    typedef enum logic [0:0] {
        PEND_IDLE = 1'b0,
        PEND_FULL = 1'b1
    } pend_state_t;

    typedef enum logic [0:0] {
        HOLD_LIVE = 1'b0,
        HOLD_HELD = 1'b1
    } hold_state_t;

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit_inst_hold_buf.sv
// ============================================================================
// inst_hold_buf : freezes the SRAM read word on the rising edge of the ID stall
// Revision: 1.0
// ============================================================================
`default_nettype none

module inst_hold_buf
    import if_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_id,
    input  logic [31:0] rdata,
    output logic [31:0] inst
);

    hold_state_t hold_state;
    hold_state_t hold_state_nxt;
    logic [31:0] hold_inst;
    logic        stall1_d;
    logic        capture;
    logic        hold_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_state <= HOLD_LIVE;
            hold_inst  <= 32'b0;
            stall1_d   <= 1'b0;
        end else begin
            hold_state <= hold_state_nxt;
            stall1_d   <= stall_id;
            if (capture) begin
                hold_inst <= rdata;
            end
        end
    end

    // Capture only on the stall's rising edge: later stall cycles see stale rdata.
    always_comb begin
        hold_state_nxt = hold_state;
        capture        = 1'b0;
        case (hold_state)
            HOLD_LIVE: begin
                if (stall_id == STOP && !stall1_d) begin
                    capture        = 1'b1;
                    hold_state_nxt = HOLD_HELD;
                end
            end
            HOLD_HELD: begin
                if (stall_id == NO_STOP) begin
                    hold_state_nxt = HOLD_LIVE;
                end
            end
            default: hold_state_nxt = HOLD_LIVE;
        endcase
    end

    assign hold_v = (hold_state == HOLD_HELD);
    assign inst   = (hold_v && !rst) ? hold_inst : rdata;

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit : MIPS IF stage - PC register, redirect buffer, SRAM request
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int          STALL_W  = DEF_STALL_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic [BR_WD-1:0]       br_bus,
    input  logic [31:0]            inst_sram_rdata,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic [31:0]            id_inst
);

    logic        br_e;
    logic [31:0] br_addr;
    logic        pc_stop;
    logic [31:0] pc_r;
    logic        ce_r;
    logic        ce_next;
    logic [31:0] next_pc;

    pend_state_t pend_state;
    pend_state_t pend_state_nxt;
    logic [31:0] pend_addr;
    logic [31:0] pend_addr_nxt;
    logic        pend_v;

    logic        unused_stall_hi;

    assign {br_e, br_addr} = br_bus;
    assign pc_stop         = (stall[0] == STOP);
    assign unused_stall_hi = ^stall[STALL_W-1:2];

    // A live branch beats a buffered one; the buffered one beats sequential flow.
    always_comb begin
        next_pc = pc_r + 32'd4;
        if (br_e) begin
            next_pc = br_addr;
        end else if (pend_v) begin
            next_pc = pend_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
            ce_r <= 1'b0;
        end else if (!pc_stop) begin
            pc_r <= next_pc;
            ce_r <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_state <= PEND_IDLE;
            pend_addr  <= 32'b0;
        end else begin
            pend_state <= pend_state_nxt;
            pend_addr  <= pend_addr_nxt;
        end
    end

    always_comb begin
        pend_state_nxt = pend_state;
        pend_addr_nxt  = pend_addr;
        case (pend_state)
            PEND_IDLE: begin
                if (pc_stop && br_e) begin
                    pend_state_nxt = PEND_FULL;
                    pend_addr_nxt  = br_addr;
                end
            end
            PEND_FULL: begin
                if (!pc_stop) begin
                    pend_state_nxt = PEND_IDLE;
                end else if (br_e) begin
                    pend_addr_nxt = br_addr;
                end
            end
            default: pend_state_nxt = PEND_IDLE;
        endcase
    end

    assign pend_v = (pend_state == PEND_FULL);

    assign ce_next         = ~rst;
    assign inst_sram_en    = ce_next;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'b0;
    assign inst_sram_addr  = pc_stop ? pc_r : next_pc;
    assign if_to_id_bus    = {ce_r, pc_r};

    inst_hold_buf u_hold (
        .clk      (clk),
        .rst      (rst),
        .stall_id (stall[1]),
        .rdata    (inst_sram_rdata),
        .inst     (id_inst)
    );

endmodule

`default_nettype wire
